// File: rtl/execute_stage_reg.sv
// execute_stage_reg: ID/EX pipeline register plus ALU operand selection.
// Define EXEC_FWD_EN to build MEM/WB forwarding; otherwise the hazard unit stalls.
module execute_stage_reg #(
  parameter int WIDTH = 32,
  parameter int RADDR = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             StallE,
  input  logic             FlushE,
  input  logic [WIDTH-1:0] RD1D,
  input  logic [WIDTH-1:0] RD2D,
  input  logic [WIDTH-1:0] ImmExtD,
  input  logic [RADDR-1:0] Rs1D,
  input  logic [RADDR-1:0] Rs2D,
  input  logic [RADDR-1:0] RdD,
  input  logic [2:0]       ALUControlD,
  input  logic             ALUSrcD,
  input  logic             RegWriteD,
  input  logic             MemWriteD,
  input  logic [1:0]       ResultSrcD,
  input  logic [WIDTH-1:0] ALUResultM,
  input  logic [RADDR-1:0] RdM,
  input  logic             RegWriteM,
  input  logic [WIDTH-1:0] ResultW,
  input  logic [RADDR-1:0] RdW,
  input  logic             RegWriteW,
  output logic [WIDTH-1:0] SrcAE,
  output logic [WIDTH-1:0] SrcBE,
  output logic [WIDTH-1:0] WriteDataE,
  output logic [2:0]       ALUControlE,
  output logic             RegWriteE,
  output logic             MemWriteE,
  output logic [1:0]       ResultSrcE,
  output logic [RADDR-1:0] RdE,
  output logic             ValidE
);

  logic [WIDTH-1:0] rd1e;
  logic [WIDTH-1:0] rd2e;
  logic [WIDTH-1:0] immexte;
  logic [RADDR-1:0] rs1e;
  logic [RADDR-1:0] rs2e;
  logic             alusrce;
  logic [WIDTH-1:0] fwda;
  logic [WIDTH-1:0] fwdb;

  // capture decode bundle; reset beats flush beats stall beats load
  always_ff @(posedge clk) begin
    if (!reset_n || FlushE) begin
      rd1e        <= '0;
      rd2e        <= '0;
      immexte     <= '0;
      rs1e        <= '0;
      rs2e        <= '0;
      RdE         <= '0;
      ALUControlE <= '0;
      alusrce     <= 1'b0;
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      ResultSrcE  <= '0;
      ValidE      <= 1'b0;
    end else if (!StallE) begin
      rd1e        <= RD1D;
      rd2e        <= RD2D;
      immexte     <= ImmExtD;
      rs1e        <= Rs1D;
      rs2e        <= Rs2D;
      RdE         <= RdD;
      ALUControlE <= ALUControlD;
      alusrce     <= ALUSrcD;
      RegWriteE   <= RegWriteD;
      MemWriteE   <= MemWriteD;
      ResultSrcE  <= ResultSrcD;
      ValidE      <= 1'b1;
    end
  end

`ifdef EXEC_FWD_EN
  logic hitam;
  logic hitaw;
  logic hitbm;
  logic hitbw;

  assign hitam = RegWriteM && (RdM != '0) && (RdM == rs1e);
  assign hitaw = RegWriteW && (RdW != '0) && (RdW == rs1e);
  assign hitbm = RegWriteM && (RdM != '0) && (RdM == rs2e);
  assign hitbw = RegWriteW && (RdW != '0) && (RdW == rs2e);

  // operand bypass: newest producer (MEM) wins over WB, x0 never bypassed
  always_comb begin
    fwda = rd1e;
    fwdb = rd2e;
    if (hitam)      fwda = ALUResultM;
    else if (hitaw) fwda = ResultW;
    if (hitbm)      fwdb = ALUResultM;
    else if (hitbw) fwdb = ResultW;
  end
`else
  logic unused_fwd;

  assign unused_fwd = ^{ALUResultM, RdM, RegWriteM,
                        ResultW, RdW, RegWriteW,
                        rs1e, rs2e};
  assign fwda = rd1e;
  assign fwdb = rd2e;
`endif

  assign SrcAE      = fwda;
  assign WriteDataE = fwdb;
  assign SrcBE      = alusrce ? immexte : fwdb;

endmodule

// File: tb/tb_execute_stage_reg.sv
// tb_execute_stage_reg: random + directed check of execute_stage_reg
// against an instruction-level model of the ID/EX slot.
module tb_execute_stage_reg;
  localparam int W = 32;
  localparam int R = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, StallE, FlushE;
  logic [W-1:0]  RD1D, RD2D, ImmExtD;
  logic [R-1:0]  Rs1D, Rs2D, RdD;
  logic [2:0]    ALUControlD;
  logic          ALUSrcD, RegWriteD, MemWriteD;
  logic [1:0]    ResultSrcD;
  logic [W-1:0]  ALUResultM, ResultW;
  logic [R-1:0]  RdM, RdW;
  logic          RegWriteM, RegWriteW;
  logic [W-1:0]  SrcAE, SrcBE, WriteDataE;
  logic [2:0]    ALUControlE;
  logic          RegWriteE, MemWriteE, ValidE;
  logic [1:0]    ResultSrcE;
  logic [R-1:0]  RdE;

  execute_stage_reg #(.WIDTH(W), .RADDR(R)) dut (
    .clk(clk), .reset_n(reset_n), .StallE(StallE), .FlushE(FlushE),
    .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .ALUControlD(ALUControlD), .ALUSrcD(ALUSrcD),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD),
    .ResultSrcD(ResultSrcD),
    .ALUResultM(ALUResultM), .RdM(RdM), .RegWriteM(RegWriteM),
    .ResultW(ResultW), .RdW(RdW), .RegWriteW(RegWriteW),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .WriteDataE(WriteDataE),
    .ALUControlE(ALUControlE), .RegWriteE(RegWriteE),
    .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .RdE(RdE), .ValidE(ValidE)
  );

  // the instruction currently sitting in EX, as the model sees it
  typedef struct {
    logic         valid;
    logic [W-1:0] a, b, imm;
    logic [R-1:0] rs1, rs2, rd;
    logic [2:0]   op;
    logic         alusrc, rw, mw;
    logic [1:0]   rs;
  } instr_t;

  instr_t m;
  int vectors = 0;
  int miscompares = 0;
  bit check_en = 1'b0;

  function automatic logic [W-1:0] operand(logic [R-1:0] idx, logic [W-1:0] rf);
`ifdef EXEC_FWD_EN
    if (RegWriteM && idx != 0 && idx == RdM) return ALUResultM;
    if (RegWriteW && idx != 0 && idx == RdW) return ResultW;
`endif
    return rf;
  endfunction

  // model: an edge either empties the slot, keeps it, or takes the new instruction
  always @(posedge clk) begin
    if (!reset_n || FlushE) begin
      m = '{valid: 1'b0, a: '0, b: '0, imm: '0, rs1: '0, rs2: '0,
            rd: '0, op: '0, alusrc: 1'b0, rw: 1'b0, mw: 1'b0, rs: '0};
    end else if (!StallE) begin
      m = '{valid: 1'b1, a: RD1D, b: RD2D, imm: ImmExtD, rs1: Rs1D,
            rs2: Rs2D, rd: RdD, op: ALUControlD, alusrc: ALUSrcD,
            rw: RegWriteD, mw: MemWriteD, rs: ResultSrcD};
    end
  end

  // compare every output against the model once per cycle
  always @(negedge clk) begin
    if (check_en) begin
      logic [W-1:0] ea, eb, ewd;
      ea  = operand(m.rs1, m.a);
      ewd = operand(m.rs2, m.b);
      eb  = m.alusrc ? m.imm : ewd;
      vectors++;
      if (SrcAE !== ea || SrcBE !== eb || WriteDataE !== ewd ||
          ALUControlE !== m.op || RegWriteE !== m.rw ||
          MemWriteE !== m.mw || ResultSrcE !== m.rs ||
          RdE !== m.rd || ValidE !== m.valid) begin
        miscompares++;
        $display("FAIL model t=%0t got A=%h B=%h WD=%h op=%0d rw=%b mw=%b rs=%0d rd=%0d v=%b exp A=%h B=%h WD=%h op=%0d rw=%b mw=%b rs=%0d rd=%0d v=%b",
                 $time, SrcAE, SrcBE, WriteDataE, ALUControlE, RegWriteE,
                 MemWriteE, ResultSrcE, RdE, ValidE, ea, eb, ewd, m.op,
                 m.rw, m.mw, m.rs, m.rd, m.valid);
      end
    end
  end

  task automatic lit(string name, logic [W-1:0] got, logic [W-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic quiet_mw();
    ALUResultM = '0; RdM = '0; RegWriteM = 1'b0;
    ResultW = '0; RdW = '0; RegWriteW = 1'b0;
  endtask

  task automatic dec(logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] imm,
                     logic [R-1:0] r1, logic [R-1:0] r2, logic [R-1:0] rd,
                     logic src, logic rw);
    RD1D = a; RD2D = b; ImmExtD = imm;
    Rs1D = r1; Rs2D = r2; RdD = rd;
    ALUControlD = 3'd0; ALUSrcD = src;
    RegWriteD = rw; MemWriteD = 1'b0; ResultSrcD = 2'd0;
  endtask

  // advance one edge, then move inputs clear of it; ends before the negedge check
  task automatic edge_();
    @(posedge clk);
    #2;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] ea;
    reset_n = 1'b0; StallE = 1'b0; FlushE = 1'b0;
    dec(32'h1234, 32'h5678, 32'h9abc, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
    quiet_mw();
    edge_();
    check_en = 1'b1;
    edge_();
    sample();
    lit("reset_srca", SrcAE, '0);
    lit("reset_srcb", SrcBE, '0);
    lit("reset_valid", {31'd0, ValidE}, 32'd0);
    lit("reset_rd", {27'd0, RdE}, 32'd0);

    reset_n = 1'b1;
    dec(32'd5, 32'd7, 32'd0, 5'd0, 5'd0, 5'd1, 1'b0, 1'b0);
    edge_();
    sample();
    lit("load_srca", SrcAE, 32'd5);
    lit("load_srcb", SrcBE, 32'd7);
    lit("load_valid", {31'd0, ValidE}, 32'd1);

    dec(32'd0, 32'h99, 32'h10, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0);
    edge_();
    sample();
    lit("imm_srcb", SrcBE, 32'h10);
    lit("imm_wdata", WriteDataE, 32'h99);

    dec(32'h11, 32'd0, 32'd0, 5'd3, 5'd0, 5'd1, 1'b0, 1'b0);
    edge_();
    StallE = 1'b1;
    RdM = 5'd3; RegWriteM = 1'b1; ALUResultM = 32'hAA;
    RdW = 5'd3; RegWriteW = 1'b1; ResultW = 32'hBB;
    sample();
`ifdef EXEC_FWD_EN
    ea = 32'hAA;
`else
    ea = 32'h11;
`endif
    lit("fwd_mem_prio", SrcAE, ea);
    RegWriteM = 1'b0;
    #1;
`ifdef EXEC_FWD_EN
    ea = 32'hBB;
`else
    ea = 32'h11;
`endif
    lit("fwd_wb", SrcAE, ea);
    StallE = 1'b0;
    quiet_mw();

    dec(32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd1, 1'b0, 1'b0);
    edge_();
    RdM = 5'd0; RegWriteM = 1'b1; ALUResultM = 32'hFF;
    sample();
    lit("x0_guard", SrcBE, 32'd0);
    quiet_mw();

    dec(32'd1, 32'd2, 32'd3, 5'd0, 5'd0, 5'd4, 1'b0, 1'b1);
    edge_();
    StallE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dec($urandom, $urandom, $urandom, 5'd9, 5'd9, 5'(i + 10), 1'b0, 1'b0);
      edge_();
      sample();
      lit("stall_hold_rd", {27'd0, RdE}, 32'd4);
    end
    FlushE = 1'b1;
    edge_();
    sample();
    lit("flush_rd", {27'd0, RdE}, 32'd0);
    lit("flush_rw", {31'd0, RegWriteE}, 32'd0);
    lit("flush_valid", {31'd0, ValidE}, 32'd0);
    FlushE = 1'b0; StallE = 1'b0;

    dec(32'd8, 32'd9, 32'd0, 5'd0, 5'd0, 5'd6, 1'b0, 1'b1);
    edge_();
    reset_n = 1'b0;
    edge_();
    sample();
    lit("midreset_valid", {31'd0, ValidE}, 32'd0);
    reset_n = 1'b1;

    for (int n = 0; n < 400; n++) begin
      reset_n   = ($urandom_range(0, 99) >= 3);
      FlushE    = ($urandom_range(0, 99) < 10);
      StallE    = ($urandom_range(0, 99) < 25);
      RD1D = $urandom; RD2D = $urandom; ImmExtD = $urandom;
      Rs1D = 5'($urandom_range(0, 3));
      Rs2D = 5'($urandom_range(0, 3));
      RdD  = 5'($urandom);
      ALUControlD = 3'($urandom);
      ALUSrcD   = 1'($urandom);
      RegWriteD = 1'($urandom);
      MemWriteD = 1'($urandom);
      ResultSrcD = 2'($urandom);
      ALUResultM = $urandom; ResultW = $urandom;
      RdM = 5'($urandom_range(0, 3));
      RdW = 5'($urandom_range(0, 3));
      RegWriteM = 1'($urandom);
      RegWriteW = 1'($urandom);
      edge_();
    end
    sample();
    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/execute_stage_reg.md
Name: execute_stage_reg

Overview:
ID/EX pipeline register plus execute-side operand selection for the 5-stage pipeline.
- Captures decoded operands and controls at the clock edge.
- Resolves RAW hazards by forwarding from the MEM and WB stages.
- Drives SrcA/SrcB/ALUControl straight into the ALU; sits between the decode stage and the ALU / EX-MEM register.

Parameters:
- WIDTH, 32, datapath width.
- RADDR, 5, register-index width.

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- reset_n  in  1  synchronous active-low reset
- StallE  in  1  hold current contents
- FlushE  in  1  insert bubble
- RD1D  in  WIDTH  decode read data 1
- RD2D  in  WIDTH  decode read data 2
- ImmExtD  in  WIDTH  extended immediate
- Rs1D  in  RADDR  source register 1 index
- Rs2D  in  RADDR  source register 2 index
- RdD  in  RADDR  destination register index
- ALUControlD  in  3  ALU op code
- ALUSrcD  in  1  1 = SrcB from immediate
- RegWriteD  in  1  register write enable
- MemWriteD  in  1  memory write enable
- ResultSrcD  in  2  writeback result select
- ALUResultM  in  WIDTH  MEM-stage ALU result
- RdM  in  RADDR  MEM-stage destination
- RegWriteM  in  1  MEM-stage write enable
- ResultW  in  WIDTH  WB-stage result
- RdW  in  RADDR  WB-stage destination
- RegWriteW  in  1  WB-stage write enable
- SrcAE  out  WIDTH  ALU operand A
- SrcBE  out  WIDTH  ALU operand B
- WriteDataE  out  WIDTH  forwarded RD2 (store data)
- ALUControlE  out  3  ALU op code
- RegWriteE, MemWriteE  out  1 each  registered controls
- ResultSrcE  out  2  registered control
- RdE  out  RADDR  registered destination
- ValidE  out  1  stage holds a real instruction

Behaviour:
- All registers update only on the rising edge of clk; no async paths.
- Priority per edge: reset_n==0 > FlushE > StallE > load.
- Reset: every register clears to 0, so ValidE=0, ALUControlE=000, controls=0, RdE=0, data=0. Outputs then read SrcAE=0, SrcBE=0, WriteDataE=0.
  - Reset asserted mid-stream discards the held instruction on that edge.
- Flush: same clear as reset; ValidE=0.
  - FlushE with StallE: flush wins.
- Stall: all registers keep their value. Forwarding muxes stay live, so SrcAE/SrcBE can change during a stall as M/W advance.
- Load: capture all D inputs; ValidE=1.
- Latency: exactly one cycle from D inputs to registered E outputs.
- Forwarding is combinational on registered Rs1E/Rs2E. For each operand X in {A,B} with index RsX:
  - If RegWriteM and RdM!=0 and RdM==RsX: use ALUResultM (MEM priority).
  - Else if RegWriteW and RdW!=0 and RdW==RsX: use ResultW.
  - Else: use the registered RD1E/RD2E.
  - Register 0 is never forwarded.
- SrcAE = forwarded A.
- WriteDataE = forwarded B.
- SrcBE = ALUSrcE ? ImmExtE : forwarded B.
- ALUControlE is passed straight through from the register; no decoding here.
- Forwarding decisions ignore ValidE. Bubbles have RegWrite=0 downstream and are never sources.

Optional Feature:
- Macro EXEC_FWD_EN.
- Defined: forwarding logic as above.
- Undefined: no comparators. SrcAE=RD1E, WriteDataE=RD2E, SrcBE=ALUSrcE?ImmExtE:RD2E. ALUResultM/RdM/RegWriteM/ResultW/RdW/RegWriteW become unused; the hazard unit must stall instead.

Test Plan:
- Reset: hold reset_n=0 two cycles with nonzero D inputs -> all outputs 0, ValidE=0. Release, load RD1D=5, RD2D=7, ALUControlD=000 -> next cycle SrcAE=5, SrcBE=7, ValidE=1.
- Immediate select: ALUSrcD=1, ImmExtD=0x10, RD2D=0x99 -> SrcBE=0x10, WriteDataE=0x99.
- Forward priority: Rs1E=3, RdM=3/RegWriteM=1/ALUResultM=0xAA, RdW=3/RegWriteW=1/ResultW=0xBB -> SrcAE=0xAA. Drop RegWriteM -> SrcAE=0xBB.
- x0 guard: Rs2E=0, RdM=0, RegWriteM=1, ALUResultM=0xFF, RD2E=0 -> SrcBE=0.
- Stall then flush: load Rd=4, assert StallE 3 cycles while changing D inputs -> RdE stays 4. Assert FlushE+StallE -> RdE=0, RegWriteE=0, ValidE=0.
- EXEC_FWD_EN undefined: same stimulus as the forward-priority case -> SrcAE equals registered RD1E.
